fma_norm_sched: RTL and testbench
=================================

# fma_norm_sched

Two-requester scheduler that shares one combinational FMA normalize/exponent-update unit between two issue lanes. It round-robin arbitrates valid/ready requests and registers the winning operands into a stage register that drives the shared unit. It captures the unit's result into a 2-entry result FIFO tagged with lane and request tag. It sits between the FMA adder/LZA stage and the rounding stage.

## Interface
Parameters:
- EXP_WIDTH, 8, exponent width
- SIG_WIDTH, 23, significand width; PRE_W = 3*(SIG_WIDTH+1)+8 (80), NRM_W = SIG_WIDTH+4 (27)
- TAG_WIDTH, 4, request tag width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-lane request valid (bit i = lane i)
- req_ready  out  2  per-lane accept; a transfer occurs when valid & ready are both high
- reqN_pre  in  PRE_W  lane N prenormalized sum (N = 0, 1)
- reqN_lza, reqN_shamt  in  6 each  lane N LZA count and alignment shift
- reqN_csmall  in  1  lane N "C exponent small" flag
- reqN_exp  in  EXP_WIDTH  lane N pre-normalization exponent
- reqN_tag  in  TAG_WIDTH  lane N opaque tag
- nu_pre, nu_lza, nu_shamt, nu_csmall, nu_exp  out  (same widths)  registered operands to the shared unit
- nu_norm  in  NRM_W  shared-unit normalized significand
- nu_nexp  in  EXP_WIDTH  shared-unit normalized exponent
- nu_corr  in  1  shared-unit exponent-correction flag
- flush  in  1  synchronous clear of all in-flight work
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  downstream accept
- res_lane  out  1  lane of head result
- res_tag  out  TAG_WIDTH  tag of head result
- res_norm, res_exp, res_corr  out  NRM_W / EXP_WIDTH / 1  head result payload

## Operation
- Stage S1: one register set of {valid, lane, tag, pre, lza, shamt, csmall, exp}. The nu_* outputs come directly from the S1 registers. The shared unit is purely combinational.
- FIFO: 2 entries of {lane, tag, norm, nexp, corr}, with a count of 0..2. res_* show the head entry.
- pop = res_valid & res_ready.
- s1_adv = S1.valid & (count < 2 | pop). When s1_adv is high, {S1.lane, S1.tag, nu_norm, nu_nexp, nu_corr} is written to the FIFO tail.
- can_accept = ~S1.valid | s1_adv.
- Arbitration: pointer ptr with reset value 0.
  - Both lanes valid: grant lane ptr.
  - One lane valid: grant that lane.
  - Neither valid: no grant.
- req_ready[i] = grant[i] & can_accept. At most one bit is high. req_ready depends combinationally on req_valid.
- Requesters must hold valid and operands stable until accepted, and must not gate valid on ready.
- On accept: the granted lane's operands load into S1, and ptr becomes the non-granted lane. The pointer does not move without an accept.
- If there is no accept and s1_adv is high, S1.valid clears.
- Simultaneous pop and push with count=2: the count stays at 2. The pushed entry lands behind the surviving entry, and order is preserved.
- Results leave in acceptance order; there is no reordering across lanes.
- flush (takes priority over everything):
  - Next edge: S1.valid and count go to 0. No push, pop or accept takes effect that cycle.
  - req_ready is forced to 0 while flush is high. ptr is unchanged.
- Width rules: payload passes through unmodified. There is no arithmetic in this block apart from the 2-bit count and the FIFO pointers, which wrap modulo 2.

## Timing
- Reset (rst_n low, asynchronous): all of the following go to 0 — S1.valid, count, FIFO pointers, ptr, req_ready, res_valid, res_lane, res_tag, res_norm, res_exp, res_corr, and all nu_* outputs.
- Reset asserted mid-operation discards all in-flight requests, with no partial outputs.
- Latency: a request accepted at edge E drives nu_* during cycle E..E+1. Its result is in the FIFO and res_valid is high after edge E+1 (when the FIFO is empty and not blocked). Minimum latency is 2 cycles, from req_valid high to res_valid high.
- Throughput: 1 request/cycle when res_ready is held high.
- Capacity: 3 in flight (S1 + 2 FIFO). A 4th request is refused while the FIFO is full and pop is 0.
- res_* hold stable while res_valid=1 and res_ready=0.

## Test plan
- Single request, lane 0:
  - Stimulus: pre[79:77]=3'b100, shamt=0, lza=0, exp=8'h80, tag=5, res_ready=1.
  - Response: req_ready[0]=1 in the same cycle; res_valid=1 two cycles later with lane=0, tag=5, res_exp=8'h81, res_corr=0.
- Contention: both lanes valid continuously for 4 cycles → grants alternate 0,1,0,1. res_lane follows the same sequence, with tags in acceptance order.
- Backpressure: res_ready=0 and lane 0 streaming tags 1..4 → tags 1–3 accepted, then req_ready=0. Raise res_ready → tags 1,2,3,4 emerge in order, with no loss or duplication.
- Full FIFO: pop and accept in the same cycle → count stays at 2, and the new tag appears after the surviving entry.
- Flush with S1 and FIFO occupied → res_valid=0 next cycle, req_ready=0 during flush, and ptr is preserved.
- Reset mid-operation: assert rst_n low between edges with 3 requests in flight → outputs go to 0 immediately. After release, the first request completes with the normal 2-cycle latency.

Source files
------------

// File: rtl/fma_norm_sched.sv
// fma_norm_sched
// Shares one combinational FMA normalize/exponent-update unit between two
// issue lanes. Requests are round-robin arbitrated, the winner is registered
// into stage S1, which drives the shared unit. The unit's result is captured
// into a 2-entry FIFO, tagged with the originating lane and request tag.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid[1:0]/req_ready    per-lane request handshake
//   reqN_pre/lza/shamt/csmall/exp/tag   lane N operands (N = 0, 1)
//   nu_pre/lza/shamt/csmall/exp registered operands to the shared unit
//   nu_norm/nu_nexp/nu_corr     shared-unit result (combinational from nu_*)
//   flush                       synchronous clear of all in-flight work
//   res_valid/res_ready         result FIFO head handshake
//   res_lane/tag/norm/exp/corr  result FIFO head entry
module fma_norm_sched #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int TAG_WIDTH = 4,
  localparam int PRE_W = 3*(SIG_WIDTH+1)+8,
  localparam int NRM_W = SIG_WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [PRE_W-1:0]     req0_pre,
  input  logic [5:0]           req0_lza,
  input  logic [5:0]           req0_shamt,
  input  logic                 req0_csmall,
  input  logic [EXP_WIDTH-1:0] req0_exp,
  input  logic [TAG_WIDTH-1:0] req0_tag,
  input  logic [PRE_W-1:0]     req1_pre,
  input  logic [5:0]           req1_lza,
  input  logic [5:0]           req1_shamt,
  input  logic                 req1_csmall,
  input  logic [EXP_WIDTH-1:0] req1_exp,
  input  logic [TAG_WIDTH-1:0] req1_tag,
  output logic [PRE_W-1:0]     nu_pre,
  output logic [5:0]           nu_lza,
  output logic [5:0]           nu_shamt,
  output logic                 nu_csmall,
  output logic [EXP_WIDTH-1:0] nu_exp,
  input  logic [NRM_W-1:0]     nu_norm,
  input  logic [EXP_WIDTH-1:0] nu_nexp,
  input  logic                 nu_corr,
  input  logic                 flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_lane,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic [NRM_W-1:0]     res_norm,
  output logic [EXP_WIDTH-1:0] res_exp,
  output logic                 res_corr
);

  logic                 vld_p1;
  logic                 lane_p1;
  logic [TAG_WIDTH-1:0] tag_p1;
  logic [PRE_W-1:0]     pre_p1;
  logic [5:0]           lza_p1;
  logic [5:0]           shamt_p1;
  logic                 csmall_p1;
  logic [EXP_WIDTH-1:0] exp_p1;

  logic                 ptr;
  logic [1:0]           grant;
  logic                 accept;
  logic                 acc_lane;
  logic                 can_accept;
  logic                 s1_adv;
  logic                 pop;

  logic                 fifo_lane [2];
  logic [TAG_WIDTH-1:0] fifo_tag  [2];
  logic [NRM_W-1:0]     fifo_norm [2];
  logic [EXP_WIDTH-1:0] fifo_exp  [2];
  logic                 fifo_corr [2];
  logic [1:0]           count;
  logic                 wr_ptr;
  logic                 rd_ptr;

  // Arbitration: round-robin only matters on contention; a lone requester
  // is granted regardless of the pointer.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  assign pop        = res_valid & res_ready;
  assign s1_adv     = vld_p1 & ((count < 2'd2) | pop);
  assign can_accept = ~vld_p1 | s1_adv;
  // rst_n gating keeps req_ready low while reset is held, even if a lane
  // is already presenting a request.
  assign req_ready  = (rst_n & ~flush & can_accept) ? grant : 2'b00;
  assign accept     = |req_ready;
  assign acc_lane   = req_ready[1];

  // Stage S1: winning operands, drives the shared unit directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      lane_p1   <= 1'b0;
      tag_p1    <= '0;
      pre_p1    <= '0;
      lza_p1    <= '0;
      shamt_p1  <= '0;
      csmall_p1 <= 1'b0;
      exp_p1    <= '0;
      ptr       <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      lane_p1   <= acc_lane;
      tag_p1    <= acc_lane ? req1_tag    : req0_tag;
      pre_p1    <= acc_lane ? req1_pre    : req0_pre;
      lza_p1    <= acc_lane ? req1_lza    : req0_lza;
      shamt_p1  <= acc_lane ? req1_shamt  : req0_shamt;
      csmall_p1 <= acc_lane ? req1_csmall : req0_csmall;
      exp_p1    <= acc_lane ? req1_exp    : req0_exp;
      ptr       <= ~acc_lane;
    end else if (s1_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  assign nu_pre    = pre_p1;
  assign nu_lza    = lza_p1;
  assign nu_shamt  = shamt_p1;
  assign nu_csmall = csmall_p1;
  assign nu_exp    = exp_p1;

  // Stage S2: result FIFO. When full, a simultaneous pop and push writes the
  // slot being vacated, which lands behind the surviving entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_lane[i] <= 1'b0;
        fifo_tag[i]  <= '0;
        fifo_norm[i] <= '0;
        fifo_exp[i]  <= '0;
        fifo_corr[i] <= 1'b0;
      end
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (s1_adv) begin
        fifo_lane[wr_ptr] <= lane_p1;
        fifo_tag[wr_ptr]  <= tag_p1;
        fifo_norm[wr_ptr] <= nu_norm;
        fifo_exp[wr_ptr]  <= nu_nexp;
        fifo_corr[wr_ptr] <= nu_corr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({s1_adv, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign res_valid = (count != 2'd0);
  assign res_lane  = fifo_lane[rd_ptr];
  assign res_tag   = fifo_tag[rd_ptr];
  assign res_norm  = fifo_norm[rd_ptr];
  assign res_exp   = fifo_exp[rd_ptr];
  assign res_corr  = fifo_corr[rd_ptr];

endmodule

// File: tb/tb_fma_norm_sched.sv
// Testbench for fma_norm_sched: a simple model of the shared normalize unit
// sits on the nu_* interface; directed vectors plus multi-cycle sequences.
module tb_fma_norm_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [79:0] req0_pre = '0, req1_pre = '0;
  logic [5:0]  req0_lza = '0, req1_lza = '0, req0_shamt = '0, req1_shamt = '0;
  logic        req0_csmall = 1'b0, req1_csmall = 1'b0;
  logic [7:0]  req0_exp = '0, req1_exp = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic [79:0] nu_pre;
  logic [5:0]  nu_lza, nu_shamt;
  logic        nu_csmall;
  logic [7:0]  nu_exp;
  logic [26:0] nu_norm;
  logic [7:0]  nu_nexp;
  logic        nu_corr;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_lane;
  logic [3:0]  res_tag;
  logic [26:0] res_norm;
  logic [7:0]  res_exp;
  logic        res_corr;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  fma_norm_sched #(.EXP_WIDTH(8), .SIG_WIDTH(23), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_pre(req0_pre), .req0_lza(req0_lza), .req0_shamt(req0_shamt),
    .req0_csmall(req0_csmall), .req0_exp(req0_exp), .req0_tag(req0_tag),
    .req1_pre(req1_pre), .req1_lza(req1_lza), .req1_shamt(req1_shamt),
    .req1_csmall(req1_csmall), .req1_exp(req1_exp), .req1_tag(req1_tag),
    .nu_pre(nu_pre), .nu_lza(nu_lza), .nu_shamt(nu_shamt),
    .nu_csmall(nu_csmall), .nu_exp(nu_exp),
    .nu_norm(nu_norm), .nu_nexp(nu_nexp), .nu_corr(nu_corr),
    .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_lane(res_lane), .res_tag(res_tag), .res_norm(res_norm),
    .res_exp(res_exp), .res_corr(res_corr)
  );

  // Stand-in for the shared normalize unit
  assign nu_norm = nu_pre[79:53] ^ {21'b0, nu_shamt};
  assign nu_nexp = nu_pre[79] ? nu_exp + 8'd1 : nu_exp - {2'b00, nu_lza};
  assign nu_corr = nu_csmall;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result-order scoreboard: accepted {lane,tag} queued, results popped in order
  always @(negedge clk) begin
    logic [4:0] e;
    if (mon_en && rst_n) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got lane=%0d tag=%0h want none", res_lane, res_tag);
        end else begin
          e = exp_q.pop_front();
          chk("res_order", 128'({res_lane, res_tag}), 128'(e));
        end
      end
      if (!flush) begin
        if (req_valid[0] && req_ready[0]) exp_q.push_back({1'b0, req0_tag});
        if (req_valid[1] && req_ready[1]) exp_q.push_back({1'b1, req1_tag});
      end
    end
  end

  task automatic do_reset();
    req_valid = 2'b00;
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid && exp_q.size() == 0) break;
    end
    chk("drain_valid", 128'(res_valid), 128'(1'b0));
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  typedef struct {
    logic        lane;
    logic [3:0]  tag;
    logic [79:0] pre;
    logic [5:0]  lza;
    logic [5:0]  shamt;
    logic        cs;
    logic [7:0]  ex;
    logic [26:0] x_norm;
    logic [7:0]  x_exp;
    logic        x_corr;
  } vec_t;

  vec_t vecs[4];

  task automatic set_lane(input logic ln, input logic [3:0] tg, input logic [79:0] pr,
                          input logic [5:0] lz, input logic [5:0] sh, input logic cs,
                          input logic [7:0] ex);
    if (ln) begin
      req1_tag = tg; req1_pre = pr; req1_lza = lz; req1_shamt = sh; req1_csmall = cs; req1_exp = ex;
    end else begin
      req0_tag = tg; req0_pre = pr; req0_lza = lz; req0_shamt = sh; req0_csmall = cs; req0_exp = ex;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'h5, 80'h8000_0000_0000_0000_0000, 6'd0, 6'd0, 1'b0, 8'h80,
                27'h4000000, 8'h81, 1'b0};
    vecs[1] = '{1'b1, 4'hA, 80'h4000_0000_0000_0000_0000, 6'd1, 6'd3, 1'b1, 8'h10,
                27'h2000003, 8'h0F, 1'b1};
    vecs[2] = '{1'b0, 4'hF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 6'd5, 6'h3F, 1'b0, 8'hFF,
                27'h7FFFFC0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 4'h0, 80'h0, 6'h3F, 6'h15, 1'b1, 8'h40,
                27'h0000015, 8'h01, 1'b1};

    // Reset state, with both lanes requesting while reset is held
    req_valid = 2'b11;
    #2;
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_res_valid", 128'(res_valid), 128'(1'b0));
    chk("rst_res_payload", 128'({res_lane, res_tag, res_norm, res_exp, res_corr}), 128'(0));
    chk("rst_nu", 128'({nu_pre, nu_lza, nu_shamt, nu_csmall, nu_exp}), 128'(0));
    req_valid = 2'b00;
    #10;
    rst_n = 1'b1;
    tick();

    // Single requests with payload checks
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      set_lane(vecs[v].lane, vecs[v].tag, vecs[v].pre, vecs[v].lza, vecs[v].shamt,
               vecs[v].cs, vecs[v].ex);
      req_valid = vecs[v].lane ? 2'b10 : 2'b01;
      @(negedge clk);
      chk("vec_ready", 128'(req_ready), 128'(vecs[v].lane ? 2'b10 : 2'b01));
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      chk("vec_nu_pre", 128'(nu_pre), 128'(vecs[v].pre));
      chk("vec_nu_exp", 128'(nu_exp), 128'(vecs[v].ex));
      chk("vec_early_valid", 128'(res_valid), 128'(1'b0));
      tick();
      @(negedge clk);
      chk("vec_res_valid", 128'(res_valid), 128'(1'b1));
      chk("vec_res_lane", 128'(res_lane), 128'(vecs[v].lane));
      chk("vec_res_tag", 128'(res_tag), 128'(vecs[v].tag));
      chk("vec_res_norm", 128'(res_norm), 128'(vecs[v].x_norm));
      chk("vec_res_exp", 128'(res_exp), 128'(vecs[v].x_exp));
      chk("vec_res_corr", 128'(res_corr), 128'(vecs[v].x_corr));
      tick();
    end

    // Contention: grants alternate 0,1,0,1
    do_reset();
    mon_en = 1'b1;
    res_ready = 1'b1;
    req0_tag = 4'd1;
    req1_tag = 4'd2;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contend_grant", 128'(req_ready), 128'((i % 2) ? 2'b10 : 2'b01));
      tick();
      if (i % 2) req1_tag = req1_tag + 4'd2;
      else       req0_tag = req0_tag + 4'd2;
    end
    req_valid = 2'b00;
    drain();

    // Backpressure: three accepted, fourth refused, then ordered release
    do_reset();
    res_ready = 1'b0;
    req_valid = 2'b01;
    for (int t = 1; t <= 3; t++) begin
      req0_tag = 4'(t);
      @(negedge clk);
      chk("bp_accept", 128'(req_ready), 128'(2'b01));
      tick();
    end
    req0_tag = 4'd4;
    @(negedge clk);
    chk("bp_full_ready", 128'(req_ready), 128'(2'b00));
    tick();
    @(negedge clk);
    chk("bp_hold_ready", 128'(req_ready), 128'(2'b00));
    chk("bp_hold_tag", 128'(res_tag), 128'(4'd1));
    chk("bp_hold_valid", 128'(res_valid), 128'(1'b1));
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_accept", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("full_pop_head", 128'(res_tag), 128'(4'd2));
    chk("full_pop_valid", 128'(res_valid), 128'(1'b1));
    tick();
    drain();

    // Flush with S1 and FIFO occupied, pointer left at lane 1
    do_reset();
    res_ready = 1'b0;
    req0_tag = 4'd1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("fl_acc1", 128'(req_ready), 128'(2'b01));
    tick();
    req0_tag = 4'd2;
    @(negedge clk);
    chk("fl_acc2", 128'(req_ready), 128'(2'b01));
    tick();
    flush = 1'b1;
    req_valid = 2'b11;
    req0_tag = 4'd6;
    req1_tag = 4'd7;
    @(negedge clk);
    chk("fl_ready_low", 128'(req_ready), 128'(2'b00));
    chk("fl_pre_valid", 128'(res_valid), 128'(1'b1));
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("fl_res_cleared", 128'(res_valid), 128'(1'b0));
    chk("fl_ptr_kept", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid = 2'b00;
    res_ready = 1'b1;
    drain();

    // Reset mid-operation with three requests in flight
    do_reset();
    res_ready = 1'b0;
    req_valid = 2'b01;
    for (int t = 1; t <= 3; t++) begin
      set_lane(1'b0, 4'(t), 80'h8000_0000_0000_0000_0001, 6'd2, 6'd1, 1'b1, 8'h55);
      @(negedge clk);
      chk("rm_accept", 128'(req_ready), 128'(2'b01));
      tick();
    end
    @(negedge clk);
    chk("rm_pre_tag", 128'(res_tag), 128'(4'd1));
    chk("rm_pre_nu_exp", 128'(nu_exp), 128'(8'h55));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rm_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rm_res_valid", 128'(res_valid), 128'(1'b0));
    chk("rm_res_payload", 128'({res_lane, res_tag, res_norm, res_exp, res_corr}), 128'(0));
    chk("rm_nu", 128'({nu_pre, nu_lza, nu_shamt, nu_csmall, nu_exp}), 128'(0));
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_lane(1'b1, 4'd9, 80'h8000_0000_0000_0000_0000, 6'd0, 6'd0, 1'b0, 8'h20);
    req_valid = 2'b10;
    res_ready = 1'b1;
    @(negedge clk);
    chk("rm_after_ready", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rm_after_early", 128'(res_valid), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("rm_after_valid", 128'(res_valid), 128'(1'b1));
    chk("rm_after_tag", 128'({res_lane, res_tag}), 128'({1'b1, 4'd9}));
    chk("rm_after_exp", 128'(res_exp), 128'(8'h21));
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
